// File: rtl/aes_wddl_rail_decoder_if.sv
// rtl/aes_wddl_rail_decoder_if.sv - WDDL dual-rail input bus and single-rail valid/ready output
interface aes_wddl_rail_decoder_if #(
  parameter int WIDTH = 128
);
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] din_n;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;

  modport master (
    output din,
    output din_n,
    output out_ready,
    input  out_valid,
    input  dout
  );

  modport slave (
    input  din,
    input  din_n,
    input  out_ready,
    output out_valid,
    output dout
  );
endinterface

// File: rtl/aes_wddl_rail_decoder.sv
// rtl/aes_wddl_rail_decoder.sv - WDDL rail-pair sampler, spacer/eval tracker and single-rail collapser
module aes_wddl_rail_decoder #(
  parameter int WIDTH     = 128,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  aes_wddl_rail_decoder_if.slave bus,
  input  logic                 i_fault_clr,
  output logic                 o_fault,
  output logic [ERR_CNT_W-1:0] o_fault_cnt,
  output logic                 o_overrun
);

  typedef enum logic [1:0] {
    S_SPC  = 2'd0,
    S_EVAL = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_din;
  logic [WIDTH-1:0]     r_din_n;
  logic [WIDTH-1:0]     r_dout;
  logic                 r_out_valid;
  logic                 r_seen_spc;
  logic                 r_fault;
  logic [ERR_CNT_W-1:0] r_fault_cnt;
  logic                 r_overrun;

  logic w_all_spc;
  logic w_all_val;
  logic w_any_ill;
  logic w_load;
  logic w_xfer;
  logic w_drop;
  logic w_seen_nxt;

  // Pair classification on the registered rails: (0,0) spacer, (1,0)/(0,1) valid, (1,1) illegal.
  assign w_all_spc = ~|(r_din | r_din_n);
  assign w_all_val = &(r_din ^ r_din_n);
  assign w_any_ill = |(r_din & r_din_n);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_din   <= '0;
      r_din_n <= '0;
    end else begin
      r_din   <= bus.din;
      r_din_n <= bus.din_n;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_SPC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_xfer      = 1'b0;
    w_drop      = 1'b0;
    w_seen_nxt  = r_seen_spc;
    unique case (r_state)
      S_SPC: begin
        if (w_all_spc) begin
          w_state_nxt = S_EVAL;
        end
      end
      S_EVAL: begin
        if (w_all_val) begin
          w_load      = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_out_valid && bus.out_ready) begin
          w_xfer      = 1'b1;
          w_seen_nxt  = 1'b0;
          w_state_nxt = S_SPC;
        end else if (r_seen_spc && w_all_val) begin
          // A fresh word completed a full spacer/eval cycle while the old one is unread.
          w_drop     = 1'b1;
          w_seen_nxt = 1'b0;
        end else if (w_all_spc) begin
          w_seen_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_SPC;
        w_seen_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_seen_spc  <= 1'b0;
    end else begin
      r_seen_spc <= w_seen_nxt;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_dout      <= r_din;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // A clear coinciding with a new event leaves the event's effect, not zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fault     <= 1'b0;
      r_fault_cnt <= '0;
      r_overrun   <= 1'b0;
    end else if (i_fault_clr) begin
      r_fault     <= w_any_ill;
      r_fault_cnt <= w_any_ill ? {{(ERR_CNT_W-1){1'b0}}, 1'b1} : '0;
      r_overrun   <= w_drop;
    end else begin
      if (w_any_ill) begin
        r_fault <= 1'b1;
        if (r_fault_cnt != {ERR_CNT_W{1'b1}}) begin
          r_fault_cnt <= r_fault_cnt + 1'b1;
        end
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.dout      = r_dout;
  assign o_fault       = r_fault;
  assign o_fault_cnt   = r_fault_cnt;
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_aes_wddl_rail_decoder.sv
// tb/tb_aes_wddl_rail_decoder.sv - directed vectors with queue scoreboard for aes_wddl_rail_decoder
module tb_aes_wddl_rail_decoder;
  localparam int WIDTH     = 128;
  localparam int ERR_CNT_W = 8;

  logic                 clk;
  logic                 rst;
  logic                 fault_clr;
  logic                 fault;
  logic [ERR_CNT_W-1:0] fault_cnt;
  logic                 overrun;

  int n_vec;
  int n_err;
  logic [WIDTH-1:0] exp_q[$];

  aes_wddl_rail_decoder_if #(.WIDTH(WIDTH)) bus ();

  aes_wddl_rail_decoder #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus),
    .i_fault_clr (fault_clr),
    .o_fault     (fault),
    .o_fault_cnt (fault_cnt),
    .o_overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d required 0", exp_q.size());
    $fatal(1, "watchdog");
  end

  // Monitor: every accepted word must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_word: got %h, required no transfer", bus.dout);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (bus.dout !== e) begin
          n_err++;
          $display("FAIL word: got %h, required %h", bus.dout, e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic [WIDTH-1:0] w);
    bus.din   = w;
    bus.din_n = ~w;
  endtask

  task automatic put_spc();
    bus.din   = '0;
    bus.din_n = '0;
  endtask

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] w0, w2, w4, wa5, w1, w5, w6, ill;
    w0  = 128'h00112233445566778899aabbccddeeff;
    w2  = 128'hdeadbeef0123456789abcdeffedcba98;
    w4  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    wa5 = {16{8'hA5}};
    w1  = 128'h11111111222222223333333344444444;
    w5  = 128'h55555555666666667777777788888888;
    w6  = 128'hcafef00dcafef00dcafef00dcafef00d;
    n_vec = 0;
    n_err = 0;

    rst = 1'b1;
    fault_clr = 1'b0;
    bus.out_ready = 1'b0;
    put_spc();
    step(2);
    chk("reset_out_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("reset_dout", bus.dout, 128'd0);
    chk("reset_fault", {127'd0, fault}, 128'd0);
    chk("reset_fault_cnt", {120'd0, fault_cnt}, 128'd0);
    chk("reset_overrun", {127'd0, overrun}, 128'd0);
    rst = 1'b0;

    // 1: basic word, two-edge latency, single-cycle valid with ready high
    step(2);
    put_word(w0);
    bus.out_ready = 1'b1;
    exp_q.push_back(w0);
    step(1);
    chk("t1_valid_after_k", {127'd0, bus.out_valid}, 128'd0);
    step(1);
    chk("t1_valid_after_k1", {127'd0, bus.out_valid}, 128'd1);
    chk("t1_dout", bus.dout, w0);
    step(1);
    chk("t1_valid_low", {127'd0, bus.out_valid}, 128'd0);

    // 2: low half still spacer for 3 cycles
    put_spc();
    step(2);
    bus.din   = {w2[127:64], 64'd0};
    bus.din_n = {~w2[127:64], 64'd0};
    step(3);
    chk("t2_partial_no_valid", {127'd0, bus.out_valid}, 128'd0);
    put_word(w2);
    exp_q.push_back(w2);
    step(2);
    chk("t2_valid", {127'd0, bus.out_valid}, 128'd1);
    chk("t2_dout", bus.dout, w2);
    step(1);

    // 3: illegal pair on bit 5 for two cycles
    put_spc();
    step(2);
    bus.din   = w4 | 128'd32;
    bus.din_n = ~w4 | 128'd32;
    step(2);
    put_spc();
    step(1);
    chk("t3_fault", {127'd0, fault}, 128'd1);
    chk("t3_fault_cnt", {120'd0, fault_cnt}, 128'd2);
    chk("t3_no_valid", {127'd0, bus.out_valid}, 128'd0);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    chk("t3_clr_fault", {127'd0, fault}, 128'd0);
    chk("t3_clr_cnt", {120'd0, fault_cnt}, 128'd0);

    // 4: held eval word is not re-issued
    put_word(w4);
    exp_q.push_back(w4);
    step(2);
    step(10);
    chk("t4_no_reissue", {127'd0, bus.out_valid}, 128'd0);
    put_spc();
    step(2);
    put_word(wa5);
    exp_q.push_back(wa5);
    step(2);
    chk("t4_a5_valid", {127'd0, bus.out_valid}, 128'd1);
    chk("t4_a5_dout", bus.dout, wa5);
    step(1);

    // 5: overrun while held
    bus.out_ready = 1'b0;
    put_spc();
    step(2);
    put_word(w1);
    exp_q.push_back(w1);
    step(2);
    chk("t5_w1_valid", {127'd0, bus.out_valid}, 128'd1);
    put_spc();
    step(2);
    chk("t5_no_overrun_yet", {127'd0, overrun}, 128'd0);
    put_word(w5);
    step(2);
    chk("t5_overrun", {127'd0, overrun}, 128'd1);
    chk("t5_dout_kept", bus.dout, w1);
    bus.out_ready = 1'b1;
    step(1);
    chk("t5_valid_low", {127'd0, bus.out_valid}, 128'd0);
    step(3);
    chk("t5_spc_wait", {127'd0, bus.out_valid}, 128'd0);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    chk("t5_overrun_clr", {127'd0, overrun}, 128'd0);

    // 6: reset mid-hold, then counter saturation
    bus.out_ready = 1'b0;
    put_spc();
    step(2);
    put_word(w6);
    step(2);
    chk("t6_hold_valid", {127'd0, bus.out_valid}, 128'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t6_rst_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("t6_rst_dout", bus.dout, 128'd0);
    bus.out_ready = 1'b1;
    bus.din   = '1;
    bus.din_n = '1;
    step(10);
    chk("t6_cnt_9", {120'd0, fault_cnt}, 128'd9);
    step(290);
    chk("t6_cnt_sat", {120'd0, fault_cnt}, 128'hFF);
    chk("t6_fault", {127'd0, fault}, 128'd1);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    chk("t6_clr_with_event", {120'd0, fault_cnt}, 128'd1);
    chk("t6_fault_after_clr", {127'd0, fault}, 128'd1);
    put_spc();
    step(2);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1);
    chk("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
